// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART peripheral:
// register offsets, status bit positions, FSM encodings and baud helpers.
package uart_pkg;

    localparam logic [7:0] REG_TX_DATA = 8'h00;
    localparam logic [7:0] REG_TX_STAT = 8'h01;
    localparam logic [7:0] REG_RX_DATA = 8'h02;
    localparam logic [7:0] REG_RX_STAT = 8'h03;

    localparam int BIT_TX_BUSY   = 0;
    localparam int BIT_RX_NEMPTY = 0;
    localparam int BIT_RX_OVR    = 1;
    localparam int BIT_RX_FERR   = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int calc_cnt_w(input int clk_hz, input int baud);
        return $clog2(calc_div(clk_hz, baud));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; caller must not push when full
// unless popping in the same cycle, and must not pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr[AW-1:0]] <= data_i;
    end

    assign data_o  = mem[rd_ptr[AW-1:0]];
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_periph.sv
// 6502-bus UART: TX_DATA/TX_STAT/RX_DATA/RX_STAT registers, 8N1 serialiser,
// oversampling-free mid-bit deserialiser and an RX FIFO.
module uart_periph
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 27000000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       uart_cs_i,
    input  logic       R_W_n,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    input  logic       uart_rx_i,
    output logic       uart_tx_o
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = calc_cnt_w(CLK_HZ, BAUD);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    logic rd_en, wr_en, tx_wr, st_clr, pop_req, push_ok, ovr_set;
    logic fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    assign rd_en   = uart_cs_i & R_W_n;
    assign wr_en   = uart_cs_i & ~R_W_n;
    assign tx_wr   = wr_en && (addr_i == REG_TX_DATA);
    assign st_clr  = wr_en && (addr_i == REG_RX_STAT);
    assign pop_req = rd_en && (addr_i == REG_RX_DATA) && !fifo_empty;

    // ---------------- TX ----------------
    tx_state_e        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_line, tx_line_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_line  <= tx_line_n;
        end
    end

    always_ff @(posedge clk_i) tx_shift <= tx_shift_n;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (tx_wr) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = data_i;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                    tx_line_n  = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                tx_line_n = 1'b1;
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign uart_tx_o = tx_line;

    // ---------------- RX ----------------
    logic             rx_s1, rx_s2, rx_s3;
    rx_state_e        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_push, ferr_set;
    logic             ovr_flag, ferr_flag;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            ovr_flag  <= 1'b0;
            ferr_flag <= 1'b0;
        end else begin
            rx_s1     <= uart_rx_i;
            rx_s2     <= rx_s1;
            rx_s3     <= rx_s2;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            ovr_flag  <= (ovr_flag & ~st_clr) | ovr_set;
            ferr_flag <= (ferr_flag & ~st_clr) | ferr_set;
        end
    end

    always_ff @(posedge clk_i) rx_shift <= rx_shift_n;

    // rx_s2 is the synchronised line; rx_s3 delays it for edge detection.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 1'b1;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    rx_push    = rx_s2;
                    ferr_set   = ~rx_s2;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = rx_push && (!fifo_full || pop_req);
    assign ovr_set = rx_push && fifo_full && !pop_req;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_ok),
        .pop_i   (pop_req),
        .data_i  (rx_shift),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        data_o = 8'h00;
        if (uart_cs_i) begin
            case (addr_i)
                REG_TX_STAT: data_o[BIT_TX_BUSY] = (tx_state != TX_IDLE);
                REG_RX_DATA: if (!fifo_empty) data_o = fifo_dout;
                REG_RX_STAT: begin
                    data_o[BIT_RX_NEMPTY] = !fifo_empty;
                    data_o[BIT_RX_OVR]    = ovr_flag;
                    data_o[BIT_RX_FERR]   = ferr_flag;
                end
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// Directed-plus-random bench for uart_periph at DIV=10, RX_DEPTH=4, with a
// frame-level reference model (bit lists and a bounded byte queue).
module tb_uart_periph;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rx;
    logic       tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovr = 1'b0;
    logic       model_ferr = 1'b0;

    uart_periph #(
        .CLK_HZ   (1000000),
        .BAUD     (100000),
        .RX_DEPTH (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .uart_cs_i (cs),
        .R_W_n     (rw),
        .addr_i    (addr),
        .data_i    (din),
        .data_o    (dout),
        .uart_rx_i (rx),
        .uart_tx_o (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 8N1 frame: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    function automatic logic [7:0] model_stat();
        return {5'b0, model_ferr, model_ovr, (model_q.size() != 0)};
    endfunction

    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                    model_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else                             model_ovr = 1'b1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = a; din = d;
        @(posedge clk);
        #1 cs = 1'b0; rw = 1'b1;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = a;
        #1 d = dout;
        @(posedge clk);
        #1 cs = 1'b0;
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit inject);
        reg_wr(8'h00, b);
        for (int k = 0; k < 10 * DIV; k++) begin
            @(negedge clk);
            if (inject && k == 35) begin
                cs = 1'b1; rw = 1'b0; addr = 8'h00; din = 8'h3C;
            end else begin
                cs = 1'b1; rw = 1'b1; addr = 8'h01;
            end
            #1 check("tx_line", {7'b0, tx}, {7'b0, frame_bit(b, k / DIV)});
            if (!(inject && k == 35)) check("tx_busy", dout, 8'h01);
        end
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = 8'h01;
        #1 check("tx_done_busy", dout, 8'h00);
        check("tx_done_line", {7'b0, tx}, 8'h01);
        cs = 1'b0;
        if (inject) begin
            for (int k = 0; k < 2 * DIV; k++) begin
                @(negedge clk);
                #1 check("tx_drop_idle", {7'b0, tx}, 8'h01);
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok, input bit poll, output int lat);
        logic bv;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            bv = (i == 9) ? stop_ok : frame_bit(b, i);
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                rx = bv;
                if (poll) begin
                    cs = 1'b1; rw = 1'b1; addr = 8'h03;
                    #1 if (lat < 0 && dout[0]) lat = i * DIV + c;
                end
            end
        end
        rx = 1'b1;
        cs = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        int lat;

        rst_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = 8'h00; din = 8'h00; rx = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("rst_tx_line", {7'b0, tx}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        reg_rd(8'h01, d); check("rst_tx_stat", d, 8'h00);
        reg_rd(8'h03, d); check("rst_rx_stat", d, 8'h00);
        reg_rd(8'h02, d); check("rst_rx_data", d, 8'h00);
        reg_rd(8'h07, d); check("unmapped_rd", d, 8'h00);

        tx_frame(8'hA5, 1'b1);
        tx_frame(8'($urandom_range(0, 255)), 1'b0);

        send_rx(8'h5A, 1'b1, 1'b1, lat);
        model_rx(8'h5A, 1'b1);
        check("rx_latency_ok", (lat >= 96 && lat <= 98) ? 8'd1 : 8'd0, 8'd1);
        reg_rd(8'h03, d); check("rx_stat_one", d, model_stat());
        reg_rd(8'h02, d); check("rx_data_5a", d, model_q.pop_front());
        reg_rd(8'h03, d); check("rx_stat_empty", d, model_stat());

        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1, 1'b0, lat);
        model_rx(b, 1'b1);
        reg_rd(8'h02, d); check("rx_data_rand", d, model_q.pop_front());

        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom_range(0, 255));
            send_rx(b, 1'b1, 1'b0, lat);
            model_rx(b, 1'b1);
        end
        reg_rd(8'h03, d); check("rx_stat_overrun", d, model_stat());
        reg_wr(8'h03, 8'hFF);
        model_ovr = 1'b0; model_ferr = 1'b0;
        reg_rd(8'h03, d); check("rx_stat_cleared", d, model_stat());
        for (int n = 0; n < DEPTH; n++) begin
            reg_rd(8'h02, d); check("rx_fifo_order", d, model_q.pop_front());
        end
        reg_rd(8'h03, d); check("rx_stat_drained", d, model_stat());
        reg_rd(8'h02, d); check("rx_empty_read", d, 8'h00);

        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b0, 1'b0, lat);
        model_rx(b, 1'b0);
        reg_rd(8'h03, d); check("rx_framing", d, model_stat());
        reg_wr(8'h03, 8'h00);
        model_ferr = 1'b0;
        reg_rd(8'h03, d); check("rx_ferr_clear", d, model_stat());

        repeat (3) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        reg_rd(8'h03, d); check("rx_glitch", d, 8'h00);
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1, 1'b0, lat);
        model_rx(b, 1'b1);
        reg_rd(8'h02, d); check("rx_after_glitch", d, model_q.pop_front());
        reg_rd(8'h03, d); check("rx_after_glitch_stat", d, model_stat());

        reg_wr(8'h00, 8'h00);
        repeat (25) @(negedge clk);
        #1 check("tx_mid_low", {7'b0, tx}, 8'h00);
        rst_n = 1'b0;
        #1 check("tx_reset_line", {7'b0, tx}, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reg_rd(8'h01, d); check("tx_reset_busy", d, 8'h00);
        check("tx_reset_idle", {7'b0, tx}, 8'h01);
        reg_rd(8'h03, d); check("reset_rx_stat", d, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
